// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory responder.
package dmem_pkg;

    // Access type codes, identical to RISC-V load/store funct3.
    localparam logic [2:0] RW_B  = 3'b000;
    localparam logic [2:0] RW_H  = 3'b001;
    localparam logic [2:0] RW_W  = 3'b010;
    localparam logic [2:0] RW_BU = 3'b100;
    localparam logic [2:0] RW_HU = 3'b101;

    // Register window offsets from MMIO_BASE.
    localparam logic [31:0] OFF_GPIO   = 32'd0;
    localparam logic [31:0] OFF_CYCLE  = 32'd4;
    localparam logic [31:0] OFF_STATUS = 32'd8;

    // Byte lanes per 32-bit word.
    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    // Unused codes (011, 110, 111) fall through to word size.
    function automatic size_e size_of(input logic [1:0] t_lo);
        case (t_lo)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    // Right-align the addressed lane(s) and sign/zero extend; bit 2 of the type selects unsigned.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  t,
                                                input logic [1:0]  lo);
        logic [31:0]        shifted;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        shifted = word >> {lo, 3'b000};
        b_s     = $signed(shifted[7:0]);
        h_s     = $signed(shifted[15:0]);
        case (size_of(t[1:0]))
            SZ_BYTE: return t[2] ? {24'd0, shifted[7:0]}  : 32'(b_s);
            SZ_HALF: return t[2] ? {16'd0, shifted[15:0]} : 32'(h_s);
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side load/store bus: the core is master, the responder is slave.
interface dmem_responder_if;
    logic        w_en;
    logic        r_en;
    logic [31:0] ram_addr;
    logic [2:0]  rw_type;
    logic [31:0] wr_mem_data;
    logic [31:0] rd_mem_data;

    modport master (
        output w_en, r_en, ram_addr, rw_type, wr_mem_data,
        input  rd_mem_data
    );

    modport slave (
        input  w_en, r_en, ram_addr, rw_type, wr_mem_data,
        output rd_mem_data
    );
endinterface

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables, synchronous write, asynchronous read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic [BE_W-1:0]       we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem_q [2**DEPTH_LOG2];

    // Commit only the enabled byte lanes; other lanes keep their contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (we[i]) begin
                mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Read returns pre-edge contents, so read-during-write sees old data.
    assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory side of the core load/store port: RAM plus GPIO/CYCLE/STATUS register window.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dmem_responder_if.slave        bus,
    output logic [31:0]            gpio_out,
    output logic                   misalign_err
);

    size_e           size;
    logic            misaligned;
    logic            in_ram;
    logic            hit_gpio;
    logic            hit_cycle;
    logic            hit_status;
    logic [BE_W-1:0] be;
    logic [BE_W-1:0] ram_we;
    logic [31:0]     wlane;
    logic [31:0]     ram_rdata;

    logic [31:0] gpio_q,  gpio_d;
    logic [31:0] cycle_q, cycle_d;
    logic        err_q,   err_d;

    // Address decode, alignment check, byte-enable and lane replication.
    always_comb begin
        size       = size_of(bus.rw_type[1:0]);
        misaligned = ((size == SZ_HALF) && bus.ram_addr[0]) ||
                     ((size == SZ_WORD) && (bus.ram_addr[1:0] != 2'b00));
        in_ram     = (bus.ram_addr[31:DEPTH_LOG2+2] == '0);
        // Register window accepts aligned word accesses only; RAM wins any overlap.
        hit_gpio   = !in_ram && (size == SZ_WORD) && (bus.ram_addr == MMIO_BASE + OFF_GPIO);
        hit_cycle  = !in_ram && (size == SZ_WORD) && (bus.ram_addr == MMIO_BASE + OFF_CYCLE);
        hit_status = !in_ram && (size == SZ_WORD) && (bus.ram_addr == MMIO_BASE + OFF_STATUS);
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << bus.ram_addr[1:0];
                wlane = {4{bus.wr_mem_data[7:0]}};
            end
            SZ_HALF: begin
                be    = 4'b0011 << {bus.ram_addr[1], 1'b0};
                wlane = {2{bus.wr_mem_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = bus.wr_mem_data;
            end
        endcase
        // Gating with rst_n drops a store that is pending while reset is asserted.
        ram_we = (bus.w_en && in_ram && !misaligned && rst_n) ? be : '0;
    end

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (bus.ram_addr[DEPTH_LOG2+1:2]),
        .wdata (wlane),
        .rdata (ram_rdata)
    );

    // Zero-latency load mux; idle, misaligned and unmapped reads return 0.
    always_comb begin
        bus.rd_mem_data = '0;
        if (bus.r_en && !misaligned) begin
            if (in_ram) begin
                bus.rd_mem_data = load_extend(ram_rdata, bus.rw_type, bus.ram_addr[1:0]);
            end else if (hit_gpio) begin
                bus.rd_mem_data = gpio_q;
            end else if (hit_cycle) begin
                bus.rd_mem_data = cycle_q;
            end else if (hit_status) begin
                bus.rd_mem_data = {31'd0, err_q};
            end
        end
    end

    // Register window next-state: CYCLE load beats increment, misalign set beats clear.
    always_comb begin
        gpio_d  = gpio_q;
        cycle_d = cycle_q + 32'd1;
        err_d   = err_q;
        if (bus.w_en && hit_gpio) begin
            gpio_d = bus.wr_mem_data;
        end
        if (bus.w_en && hit_cycle) begin
            cycle_d = bus.wr_mem_data;
        end
        if (bus.w_en && hit_status && bus.wr_mem_data[0]) begin
            err_d = 1'b0;
        end
        if ((bus.w_en || bus.r_en) && misaligned) begin
            err_d = 1'b1;
        end
    end

    // Register window state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_q  <= '0;
            cycle_q <= '0;
            err_q   <= 1'b0;
        end else begin
            gpio_q  <= gpio_d;
            cycle_q <= cycle_d;
            err_q   <= err_d;
        end
    end

    assign gpio_out     = gpio_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed accesses push expectations, a negedge monitor checks them.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam logic [31:0] MB = 32'h0000_1000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] gpio_out;
    logic        misalign_err;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_LOG2 (8),
        .MMIO_BASE  (MB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .gpio_out     (gpio_out),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // sel: 0 = rd_mem_data, 1 = gpio_out, 2 = misalign_err
    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input int when, input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = when;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic op(input logic w, input logic r, input logic [31:0] a,
                      input logic [2:0] t, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.w_en        = w;
        bus.r_en        = r;
        bus.ram_addr    = a;
        bus.rw_type     = t;
        bus.wr_mem_data = d;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [2:0] t,
                          input logic [31:0] v, input string nm);
        op(1'b0, 1'b1, a, t, 32'd0);
        push(cyc, 0, v, nm);
    endtask

    // Monitor: compare every expectation due this cycle, flag any that were missed.
    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                case (sb[i].sel)
                    0:       act = bus.rd_mem_data;
                    1:       act = gpio_out;
                    default: act = {31'd0, misalign_err};
                endcase
                checks++;
                if (sb[i].cyc < cyc) begin
                    errors++;
                    $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)",
                             sb[i].name, sb[i].cyc, cyc);
                end else if (act !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", sb[i].name, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        bus.w_en        = 1'b0;
        bus.r_en        = 1'b0;
        bus.ram_addr    = '0;
        bus.rw_type     = RW_W;
        bus.wr_mem_data = '0;

        // Reset state
        rd_chk(MB + 4, RW_W, 32'd0, "rst_cycle0");
        push(cyc, 1, 32'd0, "rst_gpio0");
        push(cyc, 2, 32'd0, "rst_err0");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Word store, then loads of every width
        op(1'b1, 1'b0, 32'h10, RW_W, 32'hDEAD_BEEF);
        rd_chk(32'h10, RW_W,  32'hDEAD_BEEF, "lw_10");
        rd_chk(32'h13, RW_B,  32'hFFFF_FFDE, "lb_13");
        rd_chk(32'h13, RW_BU, 32'h0000_00DE, "lbu_13");
        rd_chk(32'h12, RW_H,  32'hFFFF_DEAD, "lh_12");
        rd_chk(32'h10, RW_HU, 32'h0000_BEEF, "lhu_10");

        // Partial stores keep other lanes
        op(1'b1, 1'b0, 32'h11, RW_B, 32'h0000_0055);
        rd_chk(32'h10, RW_W, 32'hDEAD_55EF, "sb_11");
        op(1'b1, 1'b0, 32'h12, RW_H, 32'h0000_1234);
        rd_chk(32'h10, RW_W, 32'h1234_55EF, "sh_12");

        // Read during write returns old data; new data next cycle
        op(1'b1, 1'b1, 32'h10, RW_W, 32'hCAFE_F00D);
        push(cyc, 0, 32'h1234_55EF, "rdw_old");
        rd_chk(32'h10, RW_W,   32'hCAFE_F00D, "rdw_new");
        rd_chk(32'h10, 3'b011, 32'hCAFE_F00D, "type011_word");

        // Misalignment: suppressed access, sticky flag, clear via STATUS
        rd_chk(32'h11, RW_H, 32'd0, "lh_misalign_rd");
        push(cyc + 1, 2, 32'd1, "misalign_set");
        op(1'b1, 1'b0, 32'h12, RW_W, 32'hFFFF_FFFF);
        rd_chk(32'h10, RW_W, 32'hCAFE_F00D, "misalign_no_store");
        rd_chk(MB + 8, RW_W, 32'd1, "status_rd");
        op(1'b1, 1'b0, MB + 8, RW_W, 32'd1);
        push(cyc, 2, 32'd1, "err_before_clr");
        push(cyc + 1, 2, 32'd0, "err_cleared");
        op(1'b0, 1'b0, 32'h10, RW_W, 32'd0);
        push(cyc, 0, 32'd0, "idle_rd0");

        // GPIO register, word-only access
        op(1'b1, 1'b0, MB, RW_W, 32'h0000_00A5);
        push(cyc + 1, 1, 32'h0000_00A5, "gpio_set");
        rd_chk(MB, RW_W, 32'h0000_00A5, "gpio_rd");
        op(1'b1, 1'b0, MB, RW_B, 32'h0000_0077);
        push(cyc + 1, 1, 32'h0000_00A5, "gpio_byte_ignored");
        rd_chk(MB, RW_B, 32'd0, "mmio_byte_rd0");

        // CYCLE load and wrap
        op(1'b1, 1'b0, MB + 4, RW_W, 32'hFFFF_FFFE);
        rd_chk(MB + 4, RW_W, 32'hFFFF_FFFE, "cycle_load");
        rd_chk(MB + 4, RW_W, 32'hFFFF_FFFF, "cycle_inc");
        rd_chk(MB + 4, RW_W, 32'h0000_0000, "cycle_wrap");

        // Unmapped window
        op(1'b1, 1'b0, 32'h2000, RW_W, 32'h1357_9BDF);
        rd_chk(32'h2000, RW_W, 32'd0, "unmapped_rd0");

        // Prepare known state, then assert reset with a store pending
        rd_chk(32'h11, RW_W, 32'd0, "lw_misalign_rd");
        op(1'b1, 1'b0, 32'h20, RW_W, 32'h1111_2222);
        push(cyc, 2, 32'd1, "err_set_pre_rst");
        rd_chk(32'h20, RW_W, 32'h1111_2222, "sw_20");
        op(1'b1, 1'b0, 32'h20, RW_W, 32'h9999_9999);
        #1 rst_n = 1'b0;
        push(cyc, 1, 32'd0, "rst_async_gpio");
        push(cyc, 2, 32'd0, "rst_async_err");
        rd_chk(MB + 4, RW_W, 32'd0, "rst_async_cycle");
        rst_n = 1'b1;
        rd_chk(MB + 4, RW_W, 32'd1, "cycle_after_rst");
        rd_chk(32'h20, RW_W, 32'h1111_2222, "rst_store_dropped");
        rd_chk(32'h2000, RW_W, 32'd0, "unmapped_after_rst");

        op(1'b0, 1'b0, 32'd0, RW_W, 32'd0);
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
